// File: rtl/bq_pkg.sv
// Shared types and helpers for the biquad coefficient loader.
package bq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrGap,
    StRdReq,
    StRdGap,
    StDone,
    StErr
  } bq_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;

  localparam int unsigned WB_WORD_BYTES = 4;

  // Sign-extend the low 'width' bits of value to 32 bits (1 <= width <= 32).
  function automatic logic [31:0] sign_extend(input logic [31:0] value, input int unsigned width);
    logic signed [31:0] shifted;
    shifted = $signed(value << (32 - width));
    return $unsigned(shifted >>> (32 - width));
  endfunction

endpackage

// File: rtl/bq_ack_timer.sv
// Per-transfer acknowledge timer: counts stalled strobe cycles and flags expiry on the
// stalled cycle that brings the count up to TIMEOUT.
module bq_ack_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // Stall counter: cleared outside a request, advances on each cycle without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // An ack in the same cycle deasserts enable, so the ack wins over expiry.
  assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bq_coef_loader.sv
// Wishbone classic initiator: writes N_COEF sign-extended coefficients to the filter's
// register file, reads each back and compares, then reports done or a sticky error.
module bq_coef_loader
  import bq_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned N_COEF    = 5,
  parameter int unsigned COEF_W    = 12,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned IDX_W    = (N_COEF > 1) ? $clog2(N_COEF) : 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     start_i,
  input  logic [N_COEF*COEF_W-1:0] coef_i,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  input  logic [31:0]              wb_dat_i,
  input  logic                     wb_ack_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic [IDX_W-1:0]         err_idx_o
);

  bq_state_e                 state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N_COEF*COEF_W-1:0]  coef_q;
  logic                      err_q, err_d;
  logic [1:0]                err_code_q, err_code_d;
  logic [IDX_W-1:0]          err_idx_q, err_idx_d;

  logic        stb;
  logic        last_idx;
  logic        expired;
  logic        accept;
  logic [31:0] coef_word;

  assign stb       = (state_q == StWrReq) || (state_q == StRdReq);
  assign last_idx  = (idx_q == IDX_W'(N_COEF - 1));
  assign accept    = (state_q == StIdle) && start_i;
  assign coef_word = sign_extend(32'(coef_q[32'(idx_q) * COEF_W +: COEF_W]), COEF_W);

  bq_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (!stb),
    .enable  (stb && !wb_ack_i),
    .expired (expired)
  );

  // Next-state and bookkeeping for the load / verify sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StWrReq;
          idx_d      = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      StWrReq: begin
        if (wb_ack_i) begin
          state_d = StWrGap;
        end else if (expired) begin
          state_d    = StErr;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
        end
      end
      StWrGap: begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = StRdReq;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StWrReq;
        end
      end
      StRdReq: begin
        if (wb_ack_i) begin
          if (wb_dat_i != coef_word) begin
            state_d    = StErr;
            err_d      = 1'b1;
            err_code_d = ERR_MISMATCH;
            err_idx_d  = idx_q;
          end else begin
            state_d = StRdGap;
          end
        end else if (expired) begin
          state_d    = StErr;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_idx_d  = idx_q;
        end
      end
      StRdGap: begin
        if (last_idx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StRdReq;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and status registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // Coefficient snapshot taken only when a start is accepted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      coef_q <= '0;
    end else if (accept) begin
      coef_q <= coef_i;
    end
  end

  // Bus outputs decode straight from state so reset removes cyc/stb without a clock.
  always_comb begin
    wb_cyc_o = stb;
    wb_stb_o = stb;
    wb_we_o  = (state_q == StWrReq);
    wb_sel_o = stb ? 4'hF : 4'h0;
    wb_adr_o = stb ? (ADDR_BASE + 32'(idx_q) * WB_WORD_BYTES) : 32'h0;
    wb_dat_o = (state_q == StWrReq) ? coef_word : 32'h0;
  end

  assign busy_o     = (state_q == StWrReq) || (state_q == StWrGap) ||
                      (state_q == StRdReq) || (state_q == StRdGap);
  assign done_o     = (state_q == StDone);
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_bq_coef_loader.sv
// Scoreboard bench for bq_coef_loader with a behavioural Wishbone register-file slave.
module tb_bq_coef_loader;

  localparam int          N    = 5;
  localparam int          CW   = 12;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            start_i  = 1'b0;
  logic [N*CW-1:0] coef_i   = '0;
  logic [31:0]     wb_dat_i = '0;
  logic            wb_ack_i = 1'b0;
  logic            wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]      wb_sel_o;
  logic [31:0]     wb_adr_o, wb_dat_o;
  logic            busy_o, done_o, err_o;
  logic [1:0]      err_code_o;
  logic [2:0]      err_idx_o;

  bq_coef_loader #(
    .ADDR_BASE (BASE),
    .N_COEF    (N),
    .COEF_W    (CW),
    .TIMEOUT   (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start_i),
    .coef_i     (coef_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .err_idx_o  (err_idx_o)
  );

  always #5 clk = ~clk;

  int tests   = 0;
  int fails   = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // kind: 0 write, 1 read, 2 done, 3 error
  typedef struct {
    int          kind;
    logic [31:0] adr;
    logic [31:0] dat;
    int          code;
    int          idx;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  // Slave behaviour knobs; transfer t is 0..N-1 for writes, N..2N-1 for reads.
  int          extra[2*N];
  int          noack_t   = -1;
  int          corrupt_t = -1;
  logic [31:0] mask      = 32'h1;
  logic [31:0] mem[N];
  int          waited    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [31:0] ref_sext(input logic [CW-1:0] c);
    int v;
    v = int'(c);
    if (v >= (1 << (CW - 1))) v = v - (1 << CW);
    return 32'(v);
  endfunction

  function automatic void push_exp(input int kind, input logic [31:0] adr,
                                   input logic [31:0] dat, input int code, input int idx,
                                   input int cyc);
    exp_t e;
    e.kind = kind; e.adr = adr; e.dat = dat; e.code = code; e.idx = idx; e.cyc = cyc;
    exp_q.push_back(e);
  endfunction

  // Reference model: walks the write-all / read-all sequence, 3 cycles per transfer plus
  // any extra slave waits, stopping at the first injected fault.
  function automatic void build_expect(input logic [N*CW-1:0] coef, input int s, input int fk,
                                       input int ft);
    int c;
    int i;
    c = s;
    for (int t = 0; t < 2 * N; t++) begin
      i = t % N;
      if (fk == 1 && t == ft) begin
        push_exp(3, 0, 0, 1, i, c + 1 + TO);
        return;
      end
      push_exp((t < N) ? 0 : 1, BASE + 32'(4 * i), ref_sext(coef[i*CW +: CW]), 0, i, 0);
      if (fk == 2 && t == ft) begin
        push_exp(3, 0, 0, 2, i, c + 3 + extra[t]);
        return;
      end
      c = c + 3 + extra[t];
    end
    push_exp(2, 0, 0, 0, 0, c + 1);
  endfunction

  function automatic logic [N*CW-1:0] rand_coef();
    logic [N*CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'($urandom);
    return r;
  endfunction

  // Register-file slave: acks after 2+extra[t] cycles of strobe, never for noack_t.
  always @(negedge clk) begin
    int i;
    int t;
    if (rst) begin
      wb_ack_i = 1'b0;
      waited   = 0;
    end else if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      waited   = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      waited++;
      i = int'((wb_adr_o - BASE) >> 2);
      if (i < 0 || i >= N) i = N - 1;
      t = wb_we_o ? i : N + i;
      if (t != noack_t && waited >= 2 + extra[t]) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) mem[i] = wb_dat_o;
        else wb_dat_i = mem[i] ^ ((t == corrupt_t) ? mask : 32'h0);
      end
    end else begin
      waited = 0;
    end
  end

  logic        prev_stb = 1'b0, prev_ack = 1'b0, prev_err = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  task automatic check_xfer();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_xfer", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("xfer_kind", wb_we_o ? 0 : 1, e.kind);
      chk("xfer_adr", wb_adr_o, e.adr);
      if (e.kind == 0) chk("wr_dat", wb_dat_o, e.dat);
    end
  endtask

  task automatic check_end(input int k);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk((k == 2) ? "unexpected_done" : "unexpected_err", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("end_kind", k, e.kind);
      chk("end_cycle", cyc_cnt, e.cyc);
      chk("busy_at_end", busy_o, 0);
      if (k == 3) begin
        chk("err_code", err_code_o, e.code);
        chk("err_idx", err_idx_o, e.idx);
      end else begin
        chk("err_at_done", err_o, 0);
      end
    end
  endtask

  // Monitor: samples mid-cycle, checks bus hygiene and pops the scoreboard on events.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("sel", wb_sel_o, wb_stb_o ? 4'hF : 4'h0);
      if (!(wb_stb_o && wb_we_o)) chk("dat_idle", wb_dat_o, 0);
      if (wb_stb_o && prev_stb && !prev_ack) begin
        chk("stable_adr", wb_adr_o, prev_adr);
        chk("stable_dat", wb_dat_o, prev_dat);
        chk("stable_we", wb_we_o, prev_we);
        chk("stable_cyc", wb_cyc_o, 1);
      end
      if (wb_cyc_o && wb_stb_o && wb_ack_i) check_xfer();
      if (done_o) check_end(2);
      if (err_o && !prev_err) check_end(3);
    end
    prev_stb = wb_stb_o;
    prev_ack = wb_ack_i;
    prev_err = err_o;
    prev_we  = wb_we_o;
    prev_adr = wb_adr_o;
    prev_dat = wb_dat_o;
  end

  task automatic clear_knobs();
    for (int t = 0; t < 2 * N; t++) extra[t] = 0;
  endtask

  task automatic issue_start(input logic [N*CW-1:0] coef, input int fk, input int ft);
    @(negedge clk);
    noack_t   = (fk == 1) ? ft : -1;
    corrupt_t = (fk == 2) ? ft : -1;
    build_expect(coef, cyc_cnt, fk, ft);
    start_i = 1'b1;
    coef_i  = coef;
    @(negedge clk);
    start_i = 1'b0;
    coef_i  = rand_coef();
    chk("busy_after_start", busy_o, 1);
    chk("err_cleared", err_o, 0);
    chk("code_cleared", err_code_o, 0);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_complete"}, (exp_q.size() == 0) ? 1 : 0, 1);
    exp_q.delete();
    k = 0;
    while (busy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_cyc"}, wb_cyc_o, 0);
    chk({name, "_stb"}, wb_stb_o, 0);
    chk({name, "_we"}, wb_we_o, 0);
    chk({name, "_sel"}, wb_sel_o, 0);
    chk({name, "_adr"}, wb_adr_o, 0);
    chk({name, "_dat"}, wb_dat_o, 0);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_err"}, err_o, 0);
    chk({name, "_code"}, err_code_o, 0);
    chk({name, "_idx"}, err_idx_o, 0);
  endtask

  task automatic check_sticky(input int code, input int idx);
    repeat (3) @(negedge clk);
    chk("sticky_err", err_o, 1);
    chk("sticky_code", err_code_o, code);
    chk("sticky_idx", err_idx_o, idx);
    chk("sticky_busy", busy_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*CW-1:0] c1;
    int fk, ft, sel;
    c1 = {12'h7FF, 12'h800, 12'h001, 12'hABC, 12'h123};
    clear_knobs();
    for (int i = 0; i < N; i++) mem[i] = '0;

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Scenario 1: single-wait slave, done 31 cycles after start.
    issue_start(c1, 0, -1);
    wait_drain("scn1");
    chk("scn1_err", err_o, 0);

    // Scenario 2: three extra waits on write 2.
    extra[2] = 3;
    issue_start(c1, 0, -1);
    wait_drain("scn2");
    clear_knobs();

    // Ack arriving on the cycle the stall count reaches TIMEOUT wins.
    extra[N + 4] = TO - 2;
    issue_start(rand_coef(), 0, -1);
    wait_drain("ack_at_limit");
    clear_knobs();

    // Scenario 3: read 3 never acked.
    issue_start(c1, 1, N + 3);
    wait_drain("scn3");
    check_sticky(1, 3);

    // Scenario 4: corrupted read 1, then a clean rerun.
    mask = 32'h0000_0100;
    issue_start(c1, 2, N + 1);
    wait_drain("scn4");
    check_sticky(2, 1);
    issue_start(c1, 0, -1);
    wait_drain("scn4_rerun");

    // Start mid-run is ignored; expectations stay those of the first start.
    issue_start(c1, 0, -1);
    repeat (6) @(negedge clk);
    start_i = 1'b1;
    coef_i  = rand_coef();
    @(negedge clk);
    start_i = 1'b0;
    chk("midstart_busy", busy_o, 1);
    wait_drain("midstart");

    // Start on the DONE cycle is ignored.
    issue_start(rand_coef(), 0, -1);
    begin
      int k;
      k = 0;
      while (!done_o && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("saw_done", done_o, 1);
    end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_on_done_ignored", busy_o, 0);
    wait_drain("done_start");

    // Asynchronous reset between clock edges during a write.
    issue_start(rand_coef(), 0, -1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_reset_stb", wb_stb_o, 1);
    rst = 1'b1;
    #1;
    chk("async_cyc", wb_cyc_o, 0);
    chk("async_stb", wb_stb_o, 0);
    chk("async_busy", busy_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("post_reset");
    end

    // Randomized runs with random wait states and faults.
    for (int r = 0; r < 20; r++) begin
      for (int t = 0; t < 2 * N; t++) extra[t] = $urandom_range(0, TO - 2);
      sel = $urandom_range(0, 3);
      fk  = (sel < 2) ? 0 : sel - 1;
      ft  = (fk == 1) ? $urandom_range(0, 2 * N - 1) : $urandom_range(N, 2 * N - 1);
      if (fk == 0) ft = -1;
      mask = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : ($urandom() | 32'h1);
      issue_start(rand_coef(), fk, ft);
      wait_drain("random");
      if (fk != 0) check_sticky(fk, ft % N);
      else chk("random_no_err", err_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
